// File: rtl/arbitro_display.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_display
// Purpose  : Round-robin arbiter sharing the 4-digit display's 16-bit input
//            among four sources, with a guaranteed on-screen dwell time.
// Revision : 1.0 - initial release
// ============================================================================
module arbitro_display #(
    parameter int unsigned TEMPO_MIN = 100_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [15:0] dado0,
    input  logic [15:0] dado1,
    input  logic [15:0] dado2,
    input  logic [15:0] dado3,
    output logic [3:0]  ack,
    output logic [15:0] dado_display,
    output logic [1:0]  fonte_atual,
    output logic        ocupado
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CONCEDE = 2'd1,
        EXIBE   = 2'd2
    } state_t;

    localparam logic [31:0] C_CONT_LOAD = 32'(TEMPO_MIN - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_g;
    logic [1:0]  r_ultimo;
    logic [31:0] r_cont;
    logic [3:0]  r_ack;
    logic [15:0] r_dado;
    logic [1:0]  r_fonte;
    logic        r_ocupado;

    logic [1:0]  w_sel;
    logic        w_decide;
    logic [15:0] w_dado_g;

    // Scan from the highest offset down so the nearest requester after the
    // last-served source wins; offset 4 wraps back onto the last source itself.
    always_comb begin
        logic [1:0] w_idx;
        w_sel = r_ultimo;
        w_idx = r_ultimo;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_ultimo + 2'(k);
            if (req[w_idx]) begin
                w_sel = w_idx;
            end
        end
    end

    assign w_decide = (r_state == OCIOSO) || ((r_state == EXIBE) && (r_cont == 32'd0));

    always_comb begin
        w_dado_g = dado0;
        case (r_g)
            2'd0:    w_dado_g = dado0;
            2'd1:    w_dado_g = dado1;
            2'd2:    w_dado_g = dado2;
            default: w_dado_g = dado3;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            OCIOSO: begin
                if (|req) begin
                    w_state_next = CONCEDE;
                end
            end
            CONCEDE: begin
                w_state_next = EXIBE;
            end
            EXIBE: begin
                if (r_cont == 32'd0) begin
                    w_state_next = (|req) ? CONCEDE : OCIOSO;
                end
            end
            default: begin
                w_state_next = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= OCIOSO;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_g       <= 2'd0;
            r_ultimo  <= 2'd3;
            r_cont    <= 32'd0;
            r_ack     <= 4'd0;
            r_dado    <= 16'd0;
            r_fonte   <= 2'd0;
            r_ocupado <= 1'b0;
        end else begin
            r_ack     <= 4'd0;
            r_ocupado <= (w_state_next != OCIOSO);
            if (w_decide && (|req)) begin
                r_g <= w_sel;
            end
            if (r_state == CONCEDE) begin
                r_dado   <= w_dado_g;
                r_fonte  <= r_g;
                r_ack    <= 4'd1 << r_g;
                r_ultimo <= r_g;
                r_cont   <= C_CONT_LOAD;
            end else if ((r_state == EXIBE) && (r_cont != 32'd0)) begin
                r_cont <= r_cont - 32'd1;
            end
        end
    end

    assign ack          = r_ack;
    assign dado_display = r_dado;
    assign fonte_atual  = r_fonte;
    assign ocupado      = r_ocupado;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbitro_display
// Purpose  : Self-checking bench for arbitro_display with a grant-timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_display;

    localparam int TM = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = 4'd0;
    logic [15:0] dado0 = 16'd0, dado1 = 16'd0, dado2 = 16'd0, dado3 = 16'd0;
    logic [3:0]  ack;
    logic [15:0] dado_display;
    logic [1:0]  fonte_atual;
    logic        ocupado;

    int n_cmp  = 0;
    int n_fail = 0;
    bit auto_drop = 1'b1;

    always #5 clk = ~clk;

    arbitro_display #(.TEMPO_MIN(TM)) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .dado0(dado0), .dado1(dado1), .dado2(dado2), .dado3(dado3),
        .ack(ack), .dado_display(dado_display),
        .fonte_atual(fonte_atual), .ocupado(ocupado)
    );

    // Reference model: tracks when the next decision is due and which grant is pending.
    int          m_edge = 0;
    int          m_next_dec = 0;
    bit          m_idle = 1'b1;
    bit          m_pend = 1'b0;
    logic [1:0]  m_pg = 2'd0;
    logic [1:0]  m_ptr = 2'd3;
    logic [3:0]  e_ack = 4'd0;
    logic [15:0] e_dado = 16'd0;
    logic [1:0]  e_fonte = 2'd0;
    logic        e_busy = 1'b0;

    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (int'(last) + k) % 4;
            if (r[idx]) return 2'(idx);
        end
        return last;
    endfunction

    function automatic logic [15:0] dado_of(input logic [1:0] i);
        logic [15:0] v [4];
        v[0] = dado0; v[1] = dado1; v[2] = dado2; v[3] = dado3;
        return v[i];
    endfunction

    always @(posedge clk) begin
        m_edge++;
        e_ack = 4'd0;
        if (reset_n !== 1'b1) begin
            m_idle = 1'b1; m_pend = 1'b0; m_ptr = 2'd3;
            e_dado = 16'd0; e_fonte = 2'd0;
        end else if (m_pend) begin
            e_ack = 4'd1 << m_pg;
            e_dado = dado_of(m_pg);
            e_fonte = m_pg;
            m_ptr = m_pg;
            m_pend = 1'b0;
            m_next_dec = m_edge + TM;
        end else if (m_idle || m_edge == m_next_dec) begin
            if (req != 4'd0) begin
                m_pg = rr_pick(req, m_ptr);
                m_pend = 1'b1;
                m_idle = 1'b0;
            end else begin
                m_idle = 1'b1;
            end
        end
        e_busy = !m_idle;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_drop) req = req & ~ack;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req = 4'd0; auto_drop = 1'b1;
        tick(); tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = 4'b1111; dado0 = 16'd99; auto_drop = 1'b1;
        tick(); tick();
        n_cmp++; if (ack !== 4'd0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        n_cmp++; if (dado_display !== 16'd0) begin n_fail++; $display("FAIL reset_dado got=%0d exp=0", dado_display); end
        n_cmp++; if (fonte_atual !== 2'd0) begin n_fail++; $display("FAIL reset_fonte got=%0d exp=0", fonte_atual); end
        n_cmp++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL reset_ocupado got=%b exp=0", ocupado); end
        reset_n = 1'b1;
        tick();
        n_cmp++; if (ack !== 4'd0) begin n_fail++; $display("FAIL reset_release_ack got=%b exp=0000", ack); end
    endtask

    task automatic test_single();
        do_reset();
        dado2 = 16'd1234; req = 4'b0100;
        tick();
        n_cmp++; if (ack !== 4'd0 || ocupado !== 1'b1) begin
            n_fail++; $display("FAIL single_E0 ack=%b ocupado=%b exp ack=0000 ocupado=1", ack, ocupado);
        end
        tick();
        n_cmp++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack got=%b exp=0100", ack); end
        n_cmp++; if (dado_display !== 16'd1234) begin n_fail++; $display("FAIL single_dado got=%0d exp=1234", dado_display); end
        n_cmp++; if (fonte_atual !== 2'd2) begin n_fail++; $display("FAIL single_fonte got=%0d exp=2", fonte_atual); end
        for (int j = 2; j <= 5; j++) begin
            tick();
            n_cmp++; if (ack !== 4'd0) begin n_fail++; $display("FAIL single_ack_clear j=%0d got=%b exp=0000", j, ack); end
            n_cmp++; if (ocupado !== (j < 5)) begin
                n_fail++; $display("FAIL single_ocupado j=%0d got=%b exp=%b", j, ocupado, (j < 5));
            end
        end
        n_cmp++; if (dado_display !== 16'd1234 || fonte_atual !== 2'd2) begin
            n_fail++; $display("FAIL single_hold dado=%0d fonte=%0d exp 1234/2", dado_display, fonte_atual);
        end
    endtask

    task automatic test_all_four();
        int ngr = 0;
        int last = 0;
        do_reset();
        dado0 = 16'd11; dado1 = 16'd22; dado2 = 16'd33; dado3 = 16'd44;
        req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ack != 4'd0) begin
                n_cmp++; if (ack !== ((ngr < 4) ? (4'd1 << ngr) : 4'd0) ||
                             dado_display !== 16'(11 * (ngr + 1))) begin
                    n_fail++; $display("FAIL all4_grant n=%0d ack=%b dado=%0d exp src=%0d dado=%0d",
                                       ngr, ack, dado_display, ngr, 11 * (ngr + 1));
                end
                if (ngr > 0) begin
                    n_cmp++; if (c - last != TM + 1) begin
                        n_fail++; $display("FAIL all4_spacing got=%0d exp=%0d", c - last, TM + 1);
                    end
                end
                last = c;
                ngr++;
            end
        end
        n_cmp++; if (ngr != 4) begin n_fail++; $display("FAIL all4_count got=%0d exp=4", ngr); end
        n_cmp++; if (ocupado !== 1'b0 || dado_display !== 16'd44) begin
            n_fail++; $display("FAIL all4_idle ocupado=%b dado=%0d exp 0/44", ocupado, dado_display);
        end
    endtask

    task automatic test_fairness();
        int ngr = 0;
        int last = 0;
        bit idle_seen = 1'b0;
        do_reset();
        auto_drop = 1'b0;
        req = 4'b1010;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ack != 4'd0) begin
                n_cmp++; if (ack !== ((ngr % 2 == 0) ? 4'b0010 : 4'b1000)) begin
                    n_fail++; $display("FAIL fair_seq n=%0d got=%b exp=%b", ngr, ack,
                                       (ngr % 2 == 0) ? 4'b0010 : 4'b1000);
                end
                if (ngr > 0) begin
                    n_cmp++; if (c - last != TM + 1) begin
                        n_fail++; $display("FAIL fair_spacing got=%0d exp=%0d", c - last, TM + 1);
                    end
                end
                last = c;
                ngr++;
            end
        end
        n_cmp++; if (ngr < 7) begin n_fail++; $display("FAIL fair_count got=%0d exp>=7", ngr); end
        req = 4'd0;
        for (int c = 0; c < 20 && !idle_seen; c++) begin
            tick();
            if (ocupado === 1'b0) idle_seen = 1'b1;
        end
        n_cmp++; if (!idle_seen) begin n_fail++; $display("FAIL fair_idle got=busy exp=idle within 20 cycles"); end
        auto_drop = 1'b1;
    endtask

    task automatic test_withdrawn();
        bit got = 1'b0;
        do_reset();
        dado0 = 16'hA5A5; dado2 = 16'h5A5A; req = 4'b0001;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (ack[0] === 1'b1) got = 1'b1;
        end
        n_cmp++; if (!got || dado_display !== 16'hA5A5) begin
            n_fail++; $display("FAIL wd_grant0 got_ack=%b dado=%h exp 1/a5a5", got, dado_display);
        end
        req = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 1) req = 4'd0;
            n_cmp++; if (ack !== 4'd0) begin n_fail++; $display("FAIL wd_noack c=%0d got=%b exp=0000", c, ack); end
            n_cmp++; if (dado_display !== 16'hA5A5) begin
                n_fail++; $display("FAIL wd_hold c=%0d got=%h exp=a5a5", c, dado_display);
            end
        end
        n_cmp++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL wd_idle got=%b exp=0", ocupado); end
    endtask

    task automatic test_reset_mid_dwell();
        bit got = 1'b0;
        do_reset();
        dado0 = 16'd7; dado3 = 16'h0333; req = 4'b0001;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (ack[0] === 1'b1) got = 1'b1;
        end
        n_cmp++; if (!got) begin n_fail++; $display("FAIL rmd_grant0 got=none exp=ack0"); end
        tick();
        reset_n = 1'b0; req = 4'b1000;
        tick();
        n_cmp++; if (ack !== 4'd0 || dado_display !== 16'd0 || fonte_atual !== 2'd0 || ocupado !== 1'b0) begin
            n_fail++; $display("FAIL rmd_reset ack=%b dado=%0d fonte=%0d oc=%b exp all 0",
                               ack, dado_display, fonte_atual, ocupado);
        end
        reset_n = 1'b1;
        tick();
        n_cmp++; if (ack !== 4'd0 || ocupado !== 1'b1) begin
            n_fail++; $display("FAIL rmd_decide ack=%b oc=%b exp 0000/1", ack, ocupado);
        end
        tick();
        n_cmp++; if (ack !== 4'b1000 || fonte_atual !== 2'd3 || dado_display !== 16'h0333) begin
            n_fail++; $display("FAIL rmd_grant3 ack=%b fonte=%0d dado=%h exp 1000/3/0333",
                               ack, fonte_atual, dado_display);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick();
            n_cmp++; if (ack !== e_ack || dado_display !== e_dado || fonte_atual !== e_fonte || ocupado !== e_busy) begin
                n_fail++; $display("FAIL rand c=%0d ack=%b/%b dado=%h/%h fonte=%0d/%0d oc=%b/%b (got/exp)",
                                   c, ack, e_ack, dado_display, e_dado, fonte_atual, e_fonte, ocupado, e_busy);
            end
            reset_n = ($urandom_range(63) != 0);
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom_range(3) == 0) begin
                    case (i)
                        0: dado0 = 16'($urandom);
                        1: dado1 = 16'($urandom);
                        2: dado2 = 16'($urandom);
                        default: dado3 = 16'($urandom);
                    endcase
                    req[i] = 1'b1;
                end
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_withdrawn();
        test_reset_mid_dwell();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
